// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg -- shared definitions for the two-client RAM arbiter.
//   DATA_W_DEF / ADDR_W_DEF / DEPTH_DEF : default data width, address width
//                                         and RAM depth
//   state_e                             : controller state (INIT clear sweep,
//                                         RUN arbitration)
package ram_arb_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector (already masked for eligibility by the caller)
//   grant[1:0] : one-hot combinational grant, zero when nothing requests
// A single priority flop records which client wins a tie. It favours client 0
// out of reset and flips to the other client whenever someone is granted, so a
// tie always goes to the client that was not granted most recently.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic prio_reg;  // 0: client 0 wins a tie, 1: client 1 wins a tie

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_reg ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg <= 1'b0;
    end else if (|grant) begin
      // Whoever just won loses the next tie.
      prio_reg <= grant[0];
    end
  end

endmodule

// File: rtl/ram_arb2.sv
// ram_arb2 -- two-client arbiter in front of a single-port-pair RAM.
//   clk, rst_n                          : clock, asynchronous active-low reset
//   cN_req/cN_we/cN_addr/cN_wdata       : client N request, held until cN_gnt
//   cN_gnt/cN_err                       : one-cycle accept pulse, out-of-range flag
//   cN_rvalid/cN_rdata                  : read-return pulse and data for client N
//   write_en/write_addr/write_data      : RAM write port (registered)
//   read_en/read_addr                   : RAM read port (registered)
//   read_data                           : RAM registered read data, 1-cycle latency
//   init_done                           : clear sweep finished, arbitration enabled
// After reset the controller writes zero to every RAM word, then arbitrates one
// access per cycle between the clients. Reads return two cycles after the
// arbitration decision, routed only to the client that issued them.
module ram_arb2
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_gnt,
  output logic              c0_err,
  output logic              c0_rvalid,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic              c1_err,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              read_en,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic              init_done
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Controller FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  state_e           state_reg, state_next;
  logic [CNT_W-1:0] sweep_reg;
  logic             sweep_active;
  logic             init_done_next;
  logic             init_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= INIT;
      sweep_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == INIT) begin
        sweep_reg <= sweep_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT:    if (sweep_reg == LAST_WORD) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    sweep_active   = (state_reg == INIT);
    // init_done follows RUN by one edge, so the last sweep write is on the
    // bus before anything is granted.
    init_done_next = (state_reg == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_reg <= 1'b0;
    end else begin
      init_done_reg <= init_done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [1:0]        gnt_reg;
  logic [1:0]        err_reg;
  logic [1:0]        eligible;
  logic [1:0]        win;
  logic              win_any;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_in_range;

  // A client holding gnt this cycle is still presenting the request it was
  // just granted for, so it must sit out one round.
  assign eligible = {c1_req, c0_req} & ~gnt_reg & {2{init_done_reg}};

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (eligible),
    .grant (win)
  );

  assign win_any      = |win;
  assign win_we       = win[1] ? c1_we    : c0_we;
  assign win_addr     = win[1] ? c1_addr  : c0_addr;
  assign win_wdata    = win[1] ? c1_wdata : c0_wdata;
  assign win_in_range = ({1'b0, win_addr} < DEPTH_EXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_reg <= 2'b00;
      err_reg <= 2'b00;
    end else begin
      gnt_reg <= win;
      err_reg <= win & {2{~win_in_range}};
    end
  end

  // ---------------------------------------------------------------------------
  // RAM ports: the clear sweep owns the write port during INIT
  // ---------------------------------------------------------------------------
  logic              write_en_reg;
  logic [ADDR_W-1:0] write_addr_reg;
  logic [DATA_W-1:0] write_data_reg;
  logic              read_en_reg;
  logic [ADDR_W-1:0] read_addr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en_reg   <= 1'b0;
      write_addr_reg <= '0;
      write_data_reg <= '0;
      read_en_reg    <= 1'b0;
      read_addr_reg  <= '0;
    end else begin
      write_en_reg <= 1'b0;
      read_en_reg  <= 1'b0;
      if (sweep_active) begin
        write_en_reg   <= 1'b1;
        write_addr_reg <= ADDR_W'(sweep_reg);
        write_data_reg <= '0;
      end else if (win_any && win_in_range) begin
        if (win_we) begin
          write_en_reg   <= 1'b1;
          write_addr_reg <= win_addr;
          write_data_reg <= win_wdata;
        end else begin
          read_en_reg   <= 1'b1;
          read_addr_reg <= win_addr;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read return tracking
  // ---------------------------------------------------------------------------
  logic       rd_pend_reg;   // read_en is on the bus this cycle
  logic       rd_owner_reg;  // client that issued it
  logic [1:0] rvalid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_reg  <= 1'b0;
      rd_owner_reg <= 1'b0;
      rvalid_reg   <= 2'b00;
    end else begin
      rd_pend_reg <= win_any && win_in_range && !win_we && !sweep_active;
      if (win_any) begin
        rd_owner_reg <= win[1];
      end
      rvalid_reg <= rd_pend_reg ? (rd_owner_reg ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. read_data is already a RAM register output, so gating it with the
  // registered rvalid keeps every client output flop-driven.
  // ---------------------------------------------------------------------------
  assign c0_gnt     = gnt_reg[0];
  assign c1_gnt     = gnt_reg[1];
  assign c0_err     = err_reg[0];
  assign c1_err     = err_reg[1];
  assign c0_rvalid  = rvalid_reg[0];
  assign c1_rvalid  = rvalid_reg[1];
  assign c0_rdata   = rvalid_reg[0] ? read_data : '0;
  assign c1_rdata   = rvalid_reg[1] ? read_data : '0;
  assign write_en   = write_en_reg;
  assign write_addr = write_addr_reg;
  assign write_data = write_data_reg;
  assign read_en    = read_en_reg;
  assign read_addr  = read_addr_reg;
  assign init_done  = init_done_reg;

endmodule
